// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared digit indices, digit limits and edit-state encoding for time setting
package time_pkg;

  localparam logic [2:0] DIG_SEC_U = 3'd0;
  localparam logic [2:0] DIG_SEC_T = 3'd1;
  localparam logic [2:0] DIG_MIN_U = 3'd2;
  localparam logic [2:0] DIG_MIN_T = 3'd3;
  localparam logic [2:0] DIG_HR_U  = 3'd4;
  localparam logic [2:0] DIG_HR_T  = 3'd5;

  localparam logic [3:0] MAX_SEC_U        = 4'd9;
  localparam logic [3:0] MAX_SEC_T        = 4'd5;
  localparam logic [3:0] MAX_MIN_U        = 4'd9;
  localparam logic [3:0] MAX_MIN_T        = 4'd5;
  localparam logic [3:0] MAX_HR_U         = 4'd9;
  localparam logic [3:0] MAX_HR_T         = 4'd2;
  localparam logic [3:0] HR_U_MAX_WHEN_20 = 4'd3;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_EDIT,
    ST_LOAD,
    ST_FIXUP,
    ST_CLRSEC
  } set_state_t;

  // Hour units are limited to 3 only while the hour tens reads 2 (20..23).
  function automatic logic [3:0] digit_max(input logic [2:0] idx, input logic [3:0] hr_tens);
    case (idx)
      DIG_SEC_U: digit_max = MAX_SEC_U;
      DIG_SEC_T: digit_max = MAX_SEC_T;
      DIG_MIN_U: digit_max = MAX_MIN_U;
      DIG_MIN_T: digit_max = MAX_MIN_T;
      DIG_HR_U:  digit_max = (hr_tens == 4'd2) ? HR_U_MAX_WHEN_20 : MAX_HR_U;
      default:   digit_max = MAX_HR_T;
    endcase
  endfunction

  function automatic logic [3:0] next_digit(input logic [3:0] cur, input logic [3:0] max_val);
    next_digit = (cur >= max_val) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// rtl/time_set_ctrl_btn_debounce.sv - button synchronizer, stable-level filter and press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample agreeing with the accepted level restarts the stability run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - front-panel time setting: edit cursor, digit load strobes, run freeze and blink
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_HALF      = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [23:0] cur_digits,
  output logic [5:0]  set,
  output logic [3:0]  setValue,
  output logic        run_en,
  output logic [2:0]  sel,
  output logic [5:0]  blank
);

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic          mode_p;
  logic          inc_p;
  set_state_t    state_q, state_nxt;
  logic [2:0]    sel_q, sel_nxt;
  logic [3:0]    val_hold;
  logic [3:0]    cur;
  logic [3:0]    new_val;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          editing, editing_nxt, blink_restart;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_mode),
    .press (mode_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .press (inc_p)
  );

  always_comb begin
    case (sel_q)
      DIG_SEC_U: cur = cur_digits[3:0];
      DIG_SEC_T: cur = cur_digits[7:4];
      DIG_MIN_U: cur = cur_digits[11:8];
      DIG_MIN_T: cur = cur_digits[15:12];
      DIG_HR_U:  cur = cur_digits[19:16];
      default:   cur = cur_digits[23:20];
    endcase
  end

  assign new_val = next_digit(cur, digit_max(sel_q, cur_digits[23:20]));

  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    set       = '0;
    setValue  = val_hold;
    run_en    = 1'b0;
    case (state_q)
      ST_RUN: begin
        run_en = 1'b1;
        if (mode_p) begin
          state_nxt = ST_EDIT;
          sel_nxt   = DIG_HR_T;
        end
      end
      ST_EDIT: begin
        if (mode_p) begin
          if (sel_q == DIG_SEC_U) state_nxt = ST_CLRSEC;
          else                    sel_nxt   = sel_q - 3'd1;
        end else if (inc_p) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        set      = 6'b000001 << sel_q;
        setValue = new_val;
        // Stepping tens to 2 while units exceed 3 would give an illegal 24..29.
        if (sel_q == DIG_HR_T && new_val == MAX_HR_T && cur_digits[19:16] > HR_U_MAX_WHEN_20)
          state_nxt = ST_FIXUP;
        else
          state_nxt = ST_EDIT;
      end
      ST_FIXUP: begin
        set       = 6'b000001 << DIG_HR_U;
        setValue  = HR_U_MAX_WHEN_20;
        state_nxt = ST_EDIT;
      end
      ST_CLRSEC: begin
        set       = 6'b000011;
        setValue  = 4'd0;
        state_nxt = ST_RUN;
        sel_nxt   = DIG_SEC_U;
      end
      default: begin
        state_nxt = ST_RUN;
        sel_nxt   = DIG_SEC_U;
      end
    endcase
  end

  assign editing       = (state_q == ST_EDIT) || (state_q == ST_LOAD) || (state_q == ST_FIXUP);
  assign editing_nxt   = (state_nxt == ST_EDIT) || (state_nxt == ST_LOAD) || (state_nxt == ST_FIXUP);
  assign blink_restart = (sel_nxt != sel_q) || (state_q == ST_RUN && state_nxt == ST_EDIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      sel_q     <= DIG_SEC_U;
      val_hold  <= 4'd0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      sel_q    <= sel_nxt;
      val_hold <= setValue;
      if (blink_restart || !editing_nxt) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign sel   = sel_q;
  assign blank = (editing && blink_ph) ? (6'b000001 << sel_q) : 6'b000000;

endmodule
